// File: rtl/thermo_seq_checker.sv
// Receive-side checker for a thermometer-coded LED fill/drain pattern bus.
// Optional THERMO_CHK_SYNC_EN adds a 2-flop input synchronizer (3-cycle latency).
module thermo_seq_checker #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 32,
    parameter int PERIOD      = 50_000_001,
    parameter int TOL         = 0,
    parameter int LOCK_STEPS  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               pat_in,
    input  logic                           clear,
    output logic [$clog2(WIDTH+1)-1:0]     level,
    output logic                           dir,
    output logic                           locked,
    output logic                           step_pulse,
    output logic                           err_shape,
    output logic                           err_jump,
    output logic                           err_timing,
    output logic [7:0]                     err_count
);
    // state  | meaning
    // SEARCH | looking for a first +/-1 step, no timing checks
    // TRACK  | following the sequence, counting good timed steps
    // LOCKED | LOCK_STEPS good steps seen, sequence in spec
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam int LW = $clog2(WIDTH+1);
    localparam int GW = $clog2(LOCK_STEPS+1);
    localparam logic [COUNT_WIDTH:0] IV_LO = (COUNT_WIDTH+1)'(PERIOD - TOL);
    localparam logic [COUNT_WIDTH:0] IV_HI = (COUNT_WIDTH+1)'(PERIOD + TOL);

    state_t                 state;
    logic [WIDTH-1:0]       pat_s;
    logic [WIDTH-1:0]       pat_d;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [GW-1:0]          good;

`ifdef THERMO_CHK_SYNC_EN
    logic [WIDTH-1:0] sync_q1, sync_q2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pat_in;
            sync_q2 <= sync_q1;
        end
    end
    assign pat_s = sync_q2;
`else
    assign pat_s = pat_in;
`endif

    logic                   changed, shape_ok, step_one, interval_ok, timeout;
    logic [LW-1:0]          new_level, exp_level;
    logic                   exp_dir;
    logic [COUNT_WIDTH:0]   interval;
    logic                   e_shape, e_jump, e_timing, err_event;

    assign changed     = (pat_s != pat_d);
    assign shape_ok    = ((pat_s & (pat_s + WIDTH'(1))) == '0);
    assign interval    = {1'b0, cnt} + (COUNT_WIDTH+1)'(1);
    assign interval_ok = (interval >= IV_LO) && (interval <= IV_HI);
    assign timeout     = (interval > IV_HI);
    // Widened by one bit so level+1 cannot wrap for any WIDTH.
    assign step_one    = ({1'b0, new_level} == {1'b0, level} + (LW+1)'(1)) ||
                         ({1'b0, level} == {1'b0, new_level} + (LW+1)'(1));

    always_comb begin
        new_level = '0;
        for (int i = 0; i < WIDTH; i++) new_level = new_level + LW'(pat_s[i]);
    end

    always_comb begin
        exp_level = level;
        exp_dir   = dir;
        if (dir) begin
            if (level < LW'(WIDTH)) exp_level = level + LW'(1);
            else begin
                exp_level = LW'(WIDTH - 1);
                exp_dir   = 1'b0;
            end
        end else begin
            if (level > '0) exp_level = level - LW'(1);
            else begin
                exp_level = LW'(1);
                exp_dir   = 1'b1;
            end
        end
    end

    always_comb begin
        e_shape  = 1'b0;
        e_jump   = 1'b0;
        e_timing = 1'b0;
        if (state == SEARCH) begin
            e_shape = changed && !shape_ok;
        end else if (changed) begin
            e_shape  = !shape_ok;
            e_jump   = shape_ok && (new_level != exp_level);
            e_timing = !interval_ok;
        end else begin
            e_timing = timeout;
        end
        err_event = e_shape || e_jump || e_timing;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            pat_d      <= '0;
            cnt        <= '0;
            good       <= '0;
            level      <= '0;
            dir        <= 1'b1;
            locked     <= 1'b0;
            step_pulse <= 1'b0;
            err_shape  <= 1'b0;
            err_jump   <= 1'b0;
            err_timing <= 1'b0;
            err_count  <= '0;
        end else begin
            pat_d      <= pat_s;
            step_pulse <= 1'b0;
            if (changed)   cnt <= '0;
            else if (!(&cnt)) cnt <= cnt + COUNT_WIDTH'(1);

            // A same-cycle error takes precedence over clear.
            if (clear) begin
                err_shape  <= e_shape;
                err_jump   <= e_jump;
                err_timing <= e_timing;
                err_count  <= err_event ? 8'd1 : 8'd0;
            end else begin
                err_shape  <= err_shape  | e_shape;
                err_jump   <= err_jump   | e_jump;
                err_timing <= err_timing | e_timing;
                if (err_event && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            end

            case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (changed && shape_ok) begin
                        level <= new_level;
                        if (step_one) begin
                            dir        <= (new_level > level);
                            step_pulse <= 1'b1;
                            good       <= '0;
                            state      <= TRACK;
                        end
                    end
                end
                TRACK, LOCKED: begin
                    if (err_event) begin
                        locked <= 1'b0;
                        state  <= SEARCH;
                    end else if (changed) begin
                        level      <= exp_level;
                        dir        <= exp_dir;
                        step_pulse <= 1'b1;
                        if (state == TRACK) begin
                            if (good == GW'(LOCK_STEPS - 1)) begin
                                locked <= 1'b1;
                                state  <= LOCKED;
                            end else begin
                                good <= good + GW'(1);
                            end
                        end
                    end
                end
                default: begin
                    locked <= 1'b0;
                    state  <= SEARCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_thermo_seq_checker.sv
// Directed bench for thermo_seq_checker with PERIOD=8, TOL=0, LOCK_STEPS=4.
module tb_thermo_seq_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pat_in;
    logic       clear;
    logic [2:0] level;
    logic       dir, locked, step_pulse;
    logic       err_shape, err_jump, err_timing;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    thermo_seq_checker #(
        .WIDTH(4), .COUNT_WIDTH(32), .PERIOD(8), .TOL(0), .LOCK_STEPS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pat_in(pat_in), .clear(clear),
        .level(level), .dir(dir), .locked(locked), .step_pulse(step_pulse),
        .err_shape(err_shape), .err_jump(err_jump), .err_timing(err_timing),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (step_pulse === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] p);
        pat_in = p;
        tick(1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic check_errs(input string tag, input logic s, input logic j,
                              input logic t, input logic [7:0] c);
        check({tag, "_shape"}, 32'(err_shape), 32'(s));
        check({tag, "_jump"}, 32'(err_jump), 32'(j));
        check({tag, "_timing"}, 32'(err_timing), 32'(t));
        check({tag, "_count"}, 32'(err_count), 32'(c));
    endtask

    initial begin
        rst_n  = 1'b0;
        pat_in = 4'b0000;
        clear  = 1'b0;
        tick(2);
        check("rst_level", 32'(level), 0);
        check("rst_dir", 32'(dir), 1);
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(step_pulse), 0);
        check_errs("rst", 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick(3);

        // 1: ideal fill then first drain step
        pulses = 0;
        go(4'b0001);
        check("t1_first_pulse", 32'(step_pulse), 1);
        check("t1_first_level", 32'(level), 1);
        tick(7); go(4'b0011);
        check("t1_lvl2", 32'(level), 2);
        tick(7); go(4'b0111);
        tick(7); go(4'b1111);
        check("t1_lvl4", 32'(level), 4);
        check("t1_not_locked_yet", 32'(locked), 0);
        tick(7); go(4'b0111);
        check("t1_locked", 32'(locked), 1);
        check("t1_level", 32'(level), 3);
        check("t1_dir", 32'(dir), 0);
        tick(1);
        check("t1_pulses", 32'(pulses), 5);
        check_errs("t1", 1'b0, 1'b0, 1'b0, 8'd0);

        // 2: shape error while locked
        tick(6); go(4'b0101);
        check_errs("t2", 1'b1, 1'b0, 1'b0, 8'd1);
        check("t2_locked", 32'(locked), 0);
        check("t2_level", 32'(level), 3);

        // 3: relock filling at level 2, then wrong jump
        do_clear();
        check_errs("t3_clr", 1'b0, 1'b0, 1'b0, 8'd0);
        go(4'b0111);
        check("t3_same_lvl_nopulse", 32'(step_pulse), 0);
        go(4'b0011);
        check("t3_acq_pulse", 32'(step_pulse), 1);
        check("t3_acq_dir", 32'(dir), 0);
        tick(7); go(4'b0001);
        tick(7); go(4'b0000);
        tick(7); go(4'b0001);
        check("t3_bounce_dir", 32'(dir), 1);
        tick(7); go(4'b0011);
        check("t3_locked", 32'(locked), 1);
        check("t3_lvl2_fill", 32'({level, dir}), 32'({3'd2, 1'b1}));
        tick(7); go(4'b0001);
        check_errs("t3_jump", 1'b0, 1'b1, 1'b0, 8'd1);
        check("t3_unlocked", 32'(locked), 0);
        check("t3_level_held", 32'(level), 2);
        tick(7); go(4'b0111);
        check("t3_reacq_pulse", 32'(step_pulse), 1);
        check("t3_reacq_level", 32'(level), 3);

        // 4: late step, then a hold timeout
        tick(7); go(4'b1111);
        tick(7); go(4'b0111);
        tick(7); go(4'b0011);
        tick(7); go(4'b0001);
        check("t4_locked", 32'(locked), 1);
        do_clear();
        tick(7); go(4'b0000);
        check_errs("t4_late", 1'b0, 1'b0, 1'b1, 8'd1);
        check("t4_late_unlock", 32'(locked), 0);
        check("t4_late_level", 32'(level), 1);
        go(4'b0011);
        check("t4_reacq_pulse", 32'(step_pulse), 1);
        do_clear();
        tick(7);
        check_errs("t4_pre_timeout", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        check_errs("t4_timeout", 1'b0, 1'b0, 1'b1, 8'd1);
        tick(10);
        check("t4_timeout_once", 32'(err_count), 1);

        // 5: clear vs error, clear alone, async reset while locked
        clear  = 1'b1;
        pat_in = 4'b0101;
        tick(1);
        clear  = 1'b0;
        check_errs("t5_clr_err", 1'b1, 1'b0, 1'b0, 8'd1);
        do_clear();
        check_errs("t5_clr_only", 1'b0, 1'b0, 1'b0, 8'd0);
        go(4'b0111);
        tick(7); go(4'b1111);
        tick(7); go(4'b0111);
        tick(7); go(4'b0011);
        tick(7); go(4'b0001);
        check("t5_locked", 32'(locked), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_locked", 32'(locked), 0);
        check("t5_async_level", 32'(level), 0);
        check("t5_async_dir", 32'(dir), 1);
        pat_in = 4'b0000;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // 6: error counter saturation
        for (int i = 0; i < 300; i++) begin
            pat_in = (i % 2 == 0) ? 4'b0101 : 4'b1010;
            tick(1);
            if (i == 253) check("t6_count_254", 32'(err_count), 254);
        end
        check("t6_sat", 32'(err_count), 255);
        check("t6_shape", 32'(err_shape), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/thermo_seq_checker.md
Name: thermo_seq_checker

Overview:
- Receive-side checker for the 4-LED fill/drain pattern bus driven by the LED sequencer.
- Observes the thermometer-coded pattern and decodes its level and direction.
- Verifies shape, step order and step interval, and locks once the sequence is stable.
- Sits on the LED bus as a self-check/monitor; its outputs feed debug LEDs or an ILA.

Parameters:
- WIDTH, 4: pattern width in bits (number of LEDs).
- COUNT_WIDTH, 32: interval counter width.
- PERIOD, 50_000_001: expected clock cycles between consecutive pattern changes (sequencer MAX_COUNT+1).
- TOL, 0: allowed ± deviation of the interval, in cycles.
- LOCK_STEPS, 4: consecutive good timed steps needed in TRACK before asserting locked.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- pat_in, input, WIDTH: observed LED pattern.
- clear, input, 1: synchronous clear of sticky error flags and err_count.
- level, output, $clog2(WIDTH+1): popcount of the last valid thermometer pattern.
- dir, output, 1: 1 = filling, 0 = draining.
- locked, output, 1: sequence tracked and in spec.
- step_pulse, output, 1: one-cycle pulse on each accepted step.
- err_shape, output, 1: sticky; non-thermometer pattern seen.
- err_jump, output, 1: sticky; illegal level transition.
- err_timing, output, 1: sticky; step interval out of tolerance, or timeout.
- err_count, output, 8: saturating total error event count.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values: level=0, dir=1, locked=0, step_pulse=0, all err_* flags 0, err_count=0, pat_d=0, interval counter=0, state SEARCH.
- Change detection: pat_in is compared with the registered copy pat_d every cycle; pat_d <= pat_in every cycle. All outputs are registered and update 1 cycle after pat_in changes.
- Thermometer-valid pattern: of the form 0…01…1; all-zeros and all-ones are valid.
- Expected next level:
  - dir=1: level+1 if level<WIDTH, else WIDTH-1 with dir flipping to 0.
  - dir=0: level-1 if level>0, else 1 with dir flipping to 1.
- Interval counter:
  - Cleared to 0 on a change cycle, otherwise incremented; saturates at all-ones.
  - Measured interval = counter+1 at the change cycle. A good interval is in [PERIOD-TOL, PERIOD+TOL].
- SEARCH state:
  - locked=0.
  - Valid change with |new-old|=1: accept, set dir=(new>old), update level, pulse step_pulse, go to TRACK with good-step count=0. No timing check.
  - Invalid shape: err_shape.
  - Valid shape with jump ≠1: update level only, no error.
- TRACK state:
  - Valid change equal to the expected level with a good interval: accept and increment good-step count; on reaching LOCK_STEPS go to LOCKED.
  - Any error: go to SEARCH.
- LOCKED state:
  - locked=1; same checks as TRACK.
  - Any error: locked=0 next cycle and go to SEARCH.
- Errors in TRACK/LOCKED:
  - Non-thermometer pattern: err_shape.
  - Valid shape but not the expected level: err_jump.
  - Bad interval: err_timing.
  - No change while counter+1 > PERIOD+TOL: err_timing timeout, raised once, then go to SEARCH.
  - Each error event increments err_count by 1, saturating at 255. Simultaneous shape and timing errors on one change count once and set both flags.
- Level on error: level and dir update only on accepted steps, or on valid-shape changes in SEARCH.
- clear: zeroes the flags and err_count. If an error occurs in the same cycle, the error wins: flag=1, err_count=1.
- Reset mid-operation: all outputs return to reset values immediately, independent of clk.

Optional Feature:
- Macro THERMO_CHK_SYNC_EN.
- Defined: pat_in passes through a 2-flop synchronizer before change detection, for pattern buses from another clock domain or board pins. Output latency becomes 3 cycles; synchronizer flops reset to 0.
- Undefined: pat_in is sampled directly with 1-cycle latency.

Test Plan:
All scenarios use WIDTH=4, PERIOD=8, TOL=0, LOCK_STEPS=4, macro undefined.
1. Ideal sequence 0000→0001→0011→0111→1111→0111, one change every 8 cycles.
   - locked=1 one cycle after the 0111 drain step.
   - 5 step_pulses; dir=0, level=3; all err_*=0.
2. Locked, then drive 0101.
   - Next cycle: err_shape=1, err_count=1, locked=0, level unchanged.
3. Locked at level 2 filling, drive 0001.
   - err_jump=1, locked=0.
   - The following valid ±1 step re-enters TRACK.
4. Locked, next change after 9 cycles.
   - err_timing=1.
   - Separately, hold the pattern for 9+ cycles: a single timeout err_timing with err_count +1, not repeated.
5. Assert clear in the same cycle as an error: err_count=1 and flag set. Assert clear alone: all zero. Assert rst_n=0 mid-LOCKED: outputs reset without a clock edge.
6. Inject 300 shape errors: err_count saturates at 255.
